apb_reg_bank: RTL and testbench

//  Parametrised APB4 slave register bank: NUM_REGS word registers, byte strobes,

---
 rtl/apb_reg_bank_pkg.sv | 33 +++
 rtl/apb_reg_bank_wait_ctr.sv | 41 ++++
 rtl/apb_reg_bank.sv | 156 +++++++++++++++
 tb/tb_apb_reg_bank.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// apb_reg_pkg : shared types and width helpers for the APB register bank
// Rev 1.0
// ============================================================================
package apb_reg_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int WAIT_CNT_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int idx_width(input int num_regs);
    return clog2(num_regs);
  endfunction

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_reg_bank_wait_ctr.sv
`default_nettype none
// ============================================================================
// apb_wait_ctr : loadable down-counter that stalls PREADY for wait states
// Rev 1.0
// ============================================================================
module apb_wait_ctr #(
  parameter int W = 4
) (
  input  logic         iClk,
  input  logic         iRsn,
  input  logic         iLoad,
  input  logic [W-1:0] iValue,
  input  logic         iDec,
  output logic         oZero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (iLoad) begin
      cnt_d = iValue;
    end else if (iDec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oZero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/apb_reg_bank.sv
`default_nettype none
// ============================================================================
// apb_reg_bank : APB4 slave register bank with byte strobes, wait states,
//                PSLVERR on bad access and hardware-backed read-only registers
// Rev 1.0
// ============================================================================
module apb_reg_bank
  import apb_reg_pkg::*;
#(
  parameter int                  DATA_W   = 32,
  parameter int                  ADDR_W   = 16,
  parameter int                  NUM_REGS = 8,
  parameter int                  WAIT_CYC = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                         iClk,
  input  logic                         iRsn,
  input  logic                         iPSEL,
  input  logic                         iPENABLE,
  input  logic                         iPWRITE,
  input  logic [ADDR_W-1:0]            iPADDR,
  input  logic [DATA_W-1:0]            iPWDATA,
  input  logic [DATA_W/8-1:0]          iPSTRB,
  output logic [DATA_W-1:0]            oPRDATA,
  output logic                         oPREADY,
  output logic                         oPSLVERR,
  input  logic [NUM_REGS*DATA_W-1:0]   iHwData,
  output logic [NUM_REGS*DATA_W-1:0]   oRegs
);

  localparam int                    IDX_W     = idx_width(NUM_REGS);
  localparam int                    STRB_W    = strb_width(DATA_W);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYC);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_q, wr_d;
  logic             err_q, err_d;

  logic             w_load;
  logic             w_dec;
  logic             w_zero;
  logic             w_ready;
  logic             w_complete;
  logic             w_commit;
  logic             w_addr_hi;
  logic             w_dec_err;
  logic [IDX_W-1:0] w_idx;
  logic [DATA_W-1:0] w_rd [NUM_REGS];
  logic             w_unused_hw;

  assign w_unused_hw = ^iHwData;

  // Address decode, evaluated on the setup cycle only.
  assign w_idx = iPADDR[IDX_W+1:2];

  always_comb begin
    w_addr_hi = 1'b0;
    for (int i = IDX_W + 2; i < ADDR_W; i++) begin
      w_addr_hi = w_addr_hi | iPADDR[i];
    end
  end

  assign w_dec_err = (iPADDR[1:0] != 2'b00) | w_addr_hi | (iPWRITE & RO_MASK[w_idx]);

  assign w_ready    = (state_q == ACCESS) & w_zero;
  assign w_complete = w_ready & iPSEL & iPENABLE;
  assign w_commit   = w_complete & wr_q & ~err_q;
  assign w_dec      = (state_q == ACCESS);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    err_d   = err_q;
    w_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (iPSEL && !iPENABLE) begin
          idx_d   = w_idx;
          wr_d    = iPWRITE;
          err_d   = w_dec_err;
          w_load  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!iPSEL || w_complete) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  apb_wait_ctr #(
    .W (WAIT_CNT_W)
  ) u_wait_ctr (
    .iClk   (iClk),
    .iRsn   (iRsn),
    .iLoad  (w_load),
    .iValue (WAIT_LOAD),
    .iDec   (w_dec),
    .oZero  (w_zero)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign w_rd[i]                   = iHwData[i*DATA_W +: DATA_W];
      assign oRegs[i*DATA_W +: DATA_W] = '0;
    end else begin : g_rw
      logic [DATA_W-1:0] reg_q;
      logic [DATA_W-1:0] reg_d;

      always_comb begin
        reg_d = reg_q;
        if (w_commit && (idx_q == IDX_W'(i))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (iPSTRB[b]) reg_d[b*8 +: 8] = iPWDATA[b*8 +: 8];
          end
        end
      end

      always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign w_rd[i]                   = reg_q;
      assign oRegs[i*DATA_W +: DATA_W] = reg_q;
    end
  end

  assign oPREADY  = w_ready;
  assign oPSLVERR = w_ready & err_q;
  assign oPRDATA  = (w_ready & ~wr_q & ~err_q) ? w_rd[idx_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_bank.sv
`default_nettype none
// ============================================================================
// tb_apb_reg_bank : three bank instances (0, 2 and 3 wait states) against an
//                   array-based reference model
// ============================================================================
module tb_apb_reg_bank;

  logic         clk;
  logic         rst_n;
  logic [2:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [15:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [255:0] hwdata;
  logic [31:0]  prdata [3];
  logic [2:0]   pready;
  logic [2:0]   pslverr;
  logic [255:0] regs [3];

  logic [31:0]  mreg [3][8];
  int           checks;
  int           failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_reg_bank #(
      .DATA_W   (32),
      .ADDR_W   (16),
      .NUM_REGS (8),
      .WAIT_CYC ((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
      .RO_MASK  (8'h80)
    ) u_dut (
      .iClk     (clk),
      .iRsn     (rst_n),
      .iPSEL    (psel[g]),
      .iPENABLE (penable),
      .iPWRITE  (pwrite),
      .iPADDR   (paddr),
      .iPWDATA  (pwdata),
      .iPSTRB   (pstrb),
      .oPRDATA  (prdata[g]),
      .oPREADY  (pready[g]),
      .oPSLVERR (pslverr[g]),
      .iHwData  (hwdata),
      .oRegs    (regs[g])
    );
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic bit exp_err(input bit wr, input logic [15:0] a);
    return (a % 4 != 0) || (a / 4 >= 8) || (wr && (a / 4 == 7));
  endfunction

  function automatic logic [31:0] exp_rd(input int d, input logic [15:0] a);
    int idx;
    idx = a / 4;
    if (exp_err(1'b0, a)) return 32'h0;
    if (idx == 7) return hwdata[idx*32 +: 32];
    return mreg[d][idx];
  endfunction

  task automatic model_write(input int d, input logic [15:0] a, input logic [31:0] wd,
                             input logic [3:0] st);
    int idx;
    idx = a / 4;
    if (exp_err(1'b1, a)) return;
    for (int b = 0; b < 4; b++) begin
      if (st[b]) mreg[d][idx][b*8 +: 8] = wd[b*8 +: 8];
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 8; i++) mreg[d][i] = 32'h0;
  endtask

  // Full setup+access transfer; cyc counts access cycles up to PREADY.
  task automatic apb_xfer(input int d, input bit wr, input logic [15:0] a,
                          input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] rd, output logic err, output int cyc);
    @(posedge clk); #1;
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 0; rd = '0; err = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cyc++;
      if (pready[d]) begin
        rd = prdata[d]; err = pslverr[d];
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable = 1'b0;
    if (wr && cyc == wait_of(d) + 1) model_write(d, a, wd, st);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    psel = 3'b111; penable = 1'b1; pwrite = 1'b0; paddr = 16'h0; pwdata = '0; pstrb = 4'hF;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: ready=%b err=%b rdata=%h, required 0/0/0",
                 d, pready[d], pslverr[d], prdata[d]);
      end
      checks++;
      if (regs[d] !== 256'h0) begin
        failures++;
        $display("FAIL reset_regs dut%0d: got %h, required 0", d, regs[d]);
      end
    end
    @(posedge clk); #1;
    psel = 3'b000; penable = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(0, 1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, rd, err, cyc);
    checks++;
    if (cyc !== 1 || err !== 1'b0) begin
      failures++;
      $display("FAIL basic_wr: cyc=%0d err=%b, required 1/0", cyc, err);
    end
    apb_xfer(0, 1'b0, 16'h0004, 32'h0, 4'h0, rd, err, cyc);
    checks++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0 || cyc !== 1) begin
      failures++;
      $display("FAIL basic_rd: rd=%h err=%b cyc=%0d, required deadbeef/0/1", rd, err, cyc);
    end
    checks++;
    if (regs[0][63:32] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_oregs: got %h, required deadbeef", regs[0][63:32]);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(0, 1'b1, 16'h0008, 32'h11223344, 4'hF, rd, err, cyc);
    apb_xfer(0, 1'b1, 16'h0008, 32'hAABBCCDD, 4'b0101, rd, err, cyc);
    apb_xfer(0, 1'b0, 16'h0008, 32'h0, 4'h0, rd, err, cyc);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL strobe_rd: got %h, required 11bb33dd", rd);
    end
  endtask

  task automatic test_wait();
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(2, 1'b1, 16'h000C, 32'hFFFFFFFF, 4'hF, rd, err, cyc);
    @(posedge clk); #1;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h000C; pwdata = 32'h5; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (pready[2] !== (k == 4)) begin
        failures++;
        $display("FAIL wait_ready cycle%0d: got %b, required %b", k, pready[2], (k == 4));
      end
      checks++;
      if (regs[2][127:96] !== 32'hFFFFFFFF) begin
        failures++;
        $display("FAIL wait_hold cycle%0d: got %h, required ffffffff", k, regs[2][127:96]);
      end
      if (k < 4) begin
        pwdata = $urandom;
        @(posedge clk); #1;
      end else begin
        pwdata = 32'h5;
      end
    end
    @(posedge clk); #1;
    psel[2] = 1'b0; penable = 1'b0;
    mreg[2][3] = 32'h5;
    @(negedge clk);
    checks++;
    if (regs[2][127:96] !== 32'h5) begin
      failures++;
      $display("FAIL wait_commit: got %h, required 00000005", regs[2][127:96]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int cyc;
    logic [15:0] bad_wr [3];
    bad_wr[0] = 16'h0040; bad_wr[1] = 16'h0002; bad_wr[2] = 16'h001C;
    for (int t = 0; t < 3; t++) begin
      apb_xfer(0, 1'b1, bad_wr[t], $urandom, 4'hF, rd, err, cyc);
      checks++;
      if (err !== 1'b1 || cyc !== 1) begin
        failures++;
        $display("FAIL err_wr @%h: err=%b cyc=%0d, required 1/1", bad_wr[t], err, cyc);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (regs[0][i*32 +: 32] !== ((i == 7) ? 32'h0 : mreg[0][i])) begin
          failures++;
          $display("FAIL err_nochange @%h reg%0d: got %h, required %h", bad_wr[t], i,
                   regs[0][i*32 +: 32], (i == 7) ? 32'h0 : mreg[0][i]);
        end
      end
    end
    apb_xfer(0, 1'b0, 16'h001C, 32'h0, 4'h0, rd, err, cyc);
    checks++;
    if (rd !== 32'hCAFE0001 || err !== 1'b0) begin
      failures++;
      $display("FAIL ro_rd: rd=%h err=%b, required cafe0001/0", rd, err);
    end
    apb_xfer(0, 1'b0, 16'h0040, 32'h0, 4'h0, rd, err, cyc);
    checks++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      failures++;
      $display("FAIL oob_rd: rd=%h err=%b, required 0/1", rd, err);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int cyc;
    @(posedge clk); #1;
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    psel[1] = 1'b0; penable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (pready[1] !== 1'b0 || regs[1][31:0] !== mreg[1][0]) begin
        failures++;
        $display("FAIL abort_state: ready=%b reg0=%h, required 0/%h", pready[1], regs[1][31:0], mreg[1][0]);
      end
    end
    // Enable without a setup cycle must not start a transfer.
    @(posedge clk); #1;
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'h0010; pwdata = 32'h77777777;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (pready[0] !== 1'b0) begin
        failures++;
        $display("FAIL nosetup_ready: got %b, required 0", pready[0]);
      end
    end
    @(posedge clk); #1;
    psel[0] = 1'b0; penable = 1'b0;
    @(negedge clk);
    checks++;
    if (regs[0][159:128] !== mreg[0][4]) begin
      failures++;
      $display("FAIL nosetup_reg4: got %h, required %h", regs[0][159:128], mreg[0][4]);
    end
    apb_xfer(1, 1'b1, 16'h0000, 32'hA5A55A5A, 4'hF, rd, err, cyc);
    checks++;
    if (cyc !== 3 || err !== 1'b0 || regs[1][31:0] !== 32'hA5A55A5A) begin
      failures++;
      $display("FAIL abort_next_wr: cyc=%0d err=%b reg0=%h, required 3/0/a5a55a5a", cyc, err, regs[1][31:0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic err; int cyc;
    int d, sel, idx;
    bit wr;
    logic [15:0] a;
    logic [31:0] wd;
    logic [3:0] st;
    logic [31:0] exp;
    for (int n = 0; n < 60; n++) begin
      d   = $urandom_range(0, 2);
      wr  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      idx = $urandom_range(0, 7);
      if (sel < 8)       a = 16'(idx * 4);
      else if (sel == 8) a = 16'(32 + $urandom_range(0, 1000) * 4);
      else               a = 16'(idx * 4 + $urandom_range(1, 3));
      wd  = $urandom;
      st  = 4'($urandom_range(0, 15));
      exp = exp_rd(d, a);
      apb_xfer(d, wr, a, wd, st, rd, err, cyc);
      checks++;
      if (cyc !== wait_of(d) + 1 || err !== exp_err(wr, a) || (!wr && rd !== exp)) begin
        failures++;
        $display("FAIL rand%0d dut%0d wr=%b a=%h: cyc=%0d err=%b rd=%h, required %0d/%b/%h",
                 n, d, wr, a, cyc, err, rd, wait_of(d) + 1, exp_err(wr, a), wr ? rd : exp);
      end
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (regs[d][i*32 +: 32] !== ((i == 7) ? 32'h0 : mreg[d][i])) begin
          failures++;
          $display("FAIL rand%0d_oregs dut%0d reg%0d: got %h, required %h", n, d, i,
                   regs[d][i*32 +: 32], (i == 7) ? 32'h0 : mreg[d][i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(1, 1'b1, 16'h0004, 32'h0BADF00D, 4'hF, rd, err, cyc);
    @(posedge clk); #1;
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0010; pwdata = 32'h13579BDF; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if (pready[1] !== 1'b0 || prdata[1] !== 32'h0 || pslverr[1] !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs: ready=%b rd=%h err=%b, required 0/0/0", pready[1], prdata[1], pslverr[1]);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (regs[d] !== 256'h0) begin
        failures++;
        $display("FAIL midrst_regs dut%0d: got %h, required 0", d, regs[d]);
      end
    end
    psel = 3'b000; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    apb_xfer(1, 1'b1, 16'h0010, 32'h2468ACE0, 4'b0011, rd, err, cyc);
    apb_xfer(1, 1'b0, 16'h0010, 32'h0, 4'h0, rd, err, cyc);
    checks++;
    if (rd !== 32'h0000ACE0 || err !== 1'b0 || cyc !== 3) begin
      failures++;
      $display("FAIL midrst_next: rd=%h err=%b cyc=%0d, required 0000ace0/0/3", rd, err, cyc);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    hwdata = '0;
    for (int i = 0; i < 7; i++) hwdata[i*32 +: 32] = $urandom;
    hwdata[255:224] = 32'hCAFE0001;
    test_reset();
    test_basic();
    test_strobe();
    test_wait();
    test_errors();
    test_abort();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
